// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA timing pipeline.
// Holds the 640x480@60 default timing, the colour-bus width rule,
// the raster-total helper and the colour-bar palette used by the
// optional test pattern (VGA_TESTPAT_EN).
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Raster counters are fixed at 10 bits (enough for 1024 columns/lines).
  localparam int CNT_W = 10;

  // Colour-bar colours as {r,g,b} channel enables.
  typedef enum logic [2:0] {
    BAR_BLACK   = 3'b000,
    BAR_BLUE    = 3'b001,
    BAR_GREEN   = 3'b010,
    BAR_CYAN    = 3'b011,
    BAR_RED     = 3'b100,
    BAR_MAGENTA = 3'b101,
    BAR_YELLOW  = 3'b110,
    BAR_WHITE   = 3'b111
  } bar_rgb_e;

  // Packed {r,g,b} bus width for a given channel width.
  function automatic int rgb_width(input int chan_w);
    return 3 * chan_w;
  endfunction

  // Total pixels per line (or lines per frame) from the four segments.
  function automatic int vga_total(input int act, input int fp,
                                   input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Bar index 0..7 (left to right) to its colour.
  function automatic bar_rgb_e bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_align_shift.sv
// Enable-gated delay line of DEPTH stages. DEPTH=0 is a plain wire so the
// caller can use it uniformly for any renderer latency.
module vga_align_shift #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_shift
      logic [WIDTH-1:0] r_sr [DEPTH];

      // Shift one stage per enable; reset clears every stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else if (i_en) begin
          r_sr[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing core: pixel-enable divider, raster counters, tile-grid
// decode, and sync/blank re-alignment to the renderer's returned colour.
// Optional build macro VGA_TESTPAT_EN replaces rgb_in with 8 colour bars.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int CLK_DIV   = 4,
  parameter int TILE_LOG2 = 5,
  parameter int PIPE_LAT  = 2,
  parameter int RGB_W     = 4,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          pix_en,
  output logic [CNT_W-1:0]              pix_x,
  output logic [CNT_W-1:0]              pix_y,
  output logic                          active,
  output logic [CNT_W-TILE_LOG2-1:0]    tile_x,
  output logic [CNT_W-TILE_LOG2-1:0]    tile_y,
  output logic [TILE_LOG2-1:0]          sub_x,
  output logic [TILE_LOG2-1:0]          sub_y,
  output logic                          frame_start,
  input  logic [rgb_width(RGB_W)-1:0]   rgb_in,
  output logic                          hsync,
  output logic                          vsync,
  output logic [RGB_W-1:0]              vga_r,
  output logic [RGB_W-1:0]              vga_g,
  output logic [RGB_W-1:0]              vga_b
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_TESTPAT_EN
  localparam logic [CNT_W-1:0] BAR_W    = CNT_W'(H_ACTIVE / 8);
  localparam int SH_W = 6;
`else
  localparam int SH_W = 3;
`endif

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_x, r_y;
  logic             r_hs, r_vs;
  logic [RGB_W-1:0] r_r, r_g, r_b;
  logic             w_active, w_hs_raw, w_vs_raw;
  logic             w_hs_d, w_vs_d, w_act_d;
  logic [SH_W-1:0]  w_sh_in, w_sh_out;

  // Pixel-enable divider: wraps at CLK_DIV-1, which is the enable clk.
  always_ff @(posedge clk) begin
    if (rst)                   r_div <= '0;
    else if (r_div == DIV_LAST) r_div <= '0;
    else                       r_div <= r_div + DIV_W'(1);
  end

  assign pix_en = (r_div == DIV_LAST);

  // Raster counters step once per pixel; line wrap advances the line count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (pix_en) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + CNT_W'(1);
      end else begin
        r_x <= r_x + CNT_W'(1);
      end
    end
  end

  assign w_active    = (r_x < X_ACT) && (r_y < Y_ACT);
  assign w_hs_raw    = (r_x >= HS_BEG) && (r_x < HS_END);
  assign w_vs_raw    = (r_y >= VS_BEG) && (r_y < VS_END);
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign active      = w_active;
  assign tile_x      = r_x[CNT_W-1:TILE_LOG2];
  assign tile_y      = r_y[CNT_W-1:TILE_LOG2];
  assign sub_x       = r_x[TILE_LOG2-1:0];
  assign sub_y       = r_y[TILE_LOG2-1:0];
  assign frame_start = pix_en && (r_x == '0) && (r_y == '0);

`ifdef VGA_TESTPAT_EN
  logic [CNT_W-1:0] w_bar_idx;
  logic [2:0]       w_bar_rgb, w_bar_d;
  assign w_bar_idx = r_x / BAR_W;
  assign w_bar_rgb = bar_colour((w_bar_idx > CNT_W'(7)) ? 3'd7 : w_bar_idx[2:0]);
  assign w_sh_in   = {w_bar_rgb, w_hs_raw, w_vs_raw, w_active};
  assign w_bar_d   = w_sh_out[5:3];
`else
  assign w_sh_in   = {w_hs_raw, w_vs_raw, w_active};
`endif

  vga_align_shift #(
    .WIDTH (SH_W),
    .DEPTH (PIPE_LAT)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .i_en (pix_en),
    .i_d  (w_sh_in),
    .o_q  (w_sh_out)
  );

  assign w_hs_d  = w_sh_out[2];
  assign w_vs_d  = w_sh_out[1];
  assign w_act_d = w_sh_out[0];

  // Output register: polarity-adjusted syncs and blanked colour, one pixel late.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs <= ~SYNC_POL;
      r_vs <= ~SYNC_POL;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else if (pix_en) begin
      r_hs <= SYNC_POL ? w_hs_d : ~w_hs_d;
      r_vs <= SYNC_POL ? w_vs_d : ~w_vs_d;
`ifdef VGA_TESTPAT_EN
      r_r  <= w_act_d ? {RGB_W{w_bar_d[2]}} : '0;
      r_g  <= w_act_d ? {RGB_W{w_bar_d[1]}} : '0;
      r_b  <= w_act_d ? {RGB_W{w_bar_d[0]}} : '0;
`else
      r_r  <= w_act_d ? rgb_in[3*RGB_W-1 -: RGB_W] : '0;
      r_g  <= w_act_d ? rgb_in[2*RGB_W-1 -: RGB_W] : '0;
      r_b  <= w_act_d ? rgb_in[RGB_W-1:0]          : '0;
`endif
    end
  end

  assign hsync = r_hs;
  assign vsync = r_vs;
  assign vga_r = r_r;
  assign vga_g = r_g;
  assign vga_b = r_b;

endmodule
